// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: register-file write port arbiter with a post-reset sweep that clears r1..r15
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   a_valid/a_ready/a_addr/a_data requester A (ALU writeback)
//   b_valid/b_ready/b_addr/b_data requester B (memory writeback)
//   hold                          register file busy, blocks all writes
//   WriteReg/DstReg/DstData       registered register-file write port
//   busy                          high while the clear sweep runs
//   rd_addr1/rd_addr2, byp_hit1/byp_hit2, byp_data  bypass taps, only with RF_ARB_BYPASS_EN
module rf_write_arbiter #(
    parameter int NREG = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_addr,
    input  logic [15:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_addr,
    input  logic [15:0] b_data,
    input  logic        hold,
`ifdef RF_ARB_BYPASS_EN
    input  logic [3:0]  rd_addr1,
    input  logic [3:0]  rd_addr2,
    output logic        byp_hit1,
    output logic        byp_hit2,
    output logic [15:0] byp_data,
`endif
    output logic        WriteReg,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    output logic        busy
);
    localparam logic [3:0] LAST = 4'(NREG - 1);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic ptr;
    logic run_ok, clear_wr, wr_en;
    logic [3:0] sel_addr, wr_addr;
    logic [15:0] sel_data, wr_data;
    assign busy = state == CLEAR;
    assign run_ok = state == RUN && !hold;
    assign clear_wr = busy && !hold;
    // ptr=0 favours A, ptr=1 favours B; it only matters when both are valid
    assign a_ready = run_ok && a_valid && (!b_valid || !ptr);
    assign b_ready = run_ok && b_valid && (!a_valid || ptr);
    assign sel_addr = b_ready ? b_addr : a_addr;
    assign sel_data = b_ready ? b_data : a_data;
    // register 0 is hardwired, so an accepted addr-0 transfer issues no write
    assign wr_en = clear_wr || ((a_ready || b_ready) && sel_addr != 4'd0);
    assign wr_addr = busy ? cnt : sel_addr;
    assign wr_data = busy ? 16'd0 : sel_data;
    always_comb begin
        state_nx = state;
        if (clear_wr && cnt == LAST) state_nx = RUN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= CLEAR;
        else state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 4'd1;
            ptr      <= 1'b0;
            WriteReg <= 1'b0;
            DstReg   <= 4'd0;
            DstData  <= 16'd0;
        end else begin
            if (clear_wr) cnt <= cnt + 4'd1;
            if (run_ok && a_valid && b_valid) ptr <= ~ptr;
            WriteReg <= wr_en;
            if (wr_en) begin
                DstReg  <= wr_addr;
                DstData <= wr_data;
            end
        end
    end
`ifdef RF_ARB_BYPASS_EN
    assign byp_hit1 = WriteReg && rd_addr1 != 4'd0 && DstReg == rd_addr1;
    assign byp_hit2 = WriteReg && rd_addr2 != 4'd0 && DstReg == rd_addr2;
    assign byp_data = DstData;
`endif
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL provide parameter NREG, default 16, meaning the number of architectural registers to sweep-clear; fixed at 16 (4-bit address).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a_valid / a_ready  input / output  1 / 1  requester A (ALU writeback) handshake.
REQ-005 a_addr / a_data  input  4 / 16  requester A destination register and data.
REQ-006 b_valid / b_ready  input / output  1 / 1  requester B (memory writeback) handshake.
REQ-007 b_addr / b_data  input  4 / 16  requester B destination register and data.
REQ-008 hold  input  1  register file busy; no write may issue while high.
REQ-009 WriteReg / DstReg / DstData  output  1 / 4 / 16  registered register-file write port.
REQ-010 busy  output  1  high while the clear sweep runs.

Function
REQ-011 SHALL be a two-state FSM: CLEAR, then RUN. CLEAR is entered on reset.
REQ-012 In CLEAR, SHALL drive WriteReg=1, DstReg=sweep count, DstData=0 on each non-hold cycle; the count runs 1..15.
REQ-013 Register 0 is never written; the CLEAR->RUN transition SHALL occur on the cycle after DstReg=15 issues.
REQ-014 In CLEAR, a_ready=b_ready=0 and busy=1. hold=1 freezes the sweep count and drives WriteReg=0.
REQ-015 In RUN with hold=0, a transfer SHALL occur when valid&ready. The ready outputs are combinational from the valid inputs, the pointer and hold.
REQ-016 One valid in RUN with hold=0: that requester SHALL get ready=1.
REQ-017 Both valid in RUN with hold=0: grant SHALL go to the round-robin pointer side. The pointer SHALL flip to the other side after every contended grant.
REQ-018 The pointer SHALL NOT change on uncontended grants. Pointer reset value is A.
REQ-019 hold=1: both ready outputs SHALL be 0 and WriteReg=0 on the next edge.
REQ-020 A granted transfer SHALL appear on WriteReg/DstReg/DstData exactly one cycle later, for one cycle only.
REQ-021 A granted transfer with addr=0 SHALL be accepted (ready=1) but SHALL produce WriteReg=0.
REQ-022 Cycles without a transfer SHALL produce WriteReg=0. DstReg/DstData SHALL keep their last values.
REQ-023 Requester data SHALL pass unmodified. At most one write SHALL issue per cycle.

Reset
REQ-024 On rst=1, asynchronously: state=CLEAR, sweep count=1, pointer=A, WriteReg=0, DstReg=0, DstData=0, busy=1.
REQ-025 When rst deasserts, the sweep SHALL restart from register 1 at the first edge.
REQ-026 Reset mid-sweep or mid-RUN SHALL discard the in-flight output write.

Configuration
REQ-027 Macro RF_ARB_BYPASS_EN defined: the block SHALL add ports rd_addr1 / rd_addr2 (input, 4), byp_hit1 / byp_hit2 (output, 1) and byp_data (output, 16).
REQ-028 With the macro, byp_hitN SHALL be 1 when WriteReg=1 and DstReg=rd_addrN≠0; byp_data SHALL equal DstData.
REQ-029 Without the macro, those ports and their logic SHALL be absent, with no other change.

Verification
REQ-030 Reset release, hold=0 -> WriteReg=1 with DstReg 1..15, DstData=0 on 15 consecutive cycles; then busy=0; ready stays low throughout.
REQ-031 RUN, a_valid only, a_addr=5, a_data=0x1234 -> a_ready=1; next cycle WriteReg=1, DstReg=5, DstData=0x1234.
REQ-032 RUN, both valid for 4 cycles (A: addr 3, 0xAAAA; B: addr 7, 0xBBBB) -> grants A,B,A,B; writes follow one cycle later.
REQ-033 RUN, hold=1 with both valid for 3 cycles -> both ready=0 and WriteReg=0; after hold drops, A is granted first.
REQ-034 RUN, b_valid, b_addr=0 -> b_ready=1, next-cycle WriteReg=0; with RF_ARB_BYPASS_EN, rd_addr1=5 during REQ-031's write cycle -> byp_hit1=1, byp_data=0x1234.
REQ-035 rst asserted at sweep count 8 -> all outputs at reset values immediately; the sweep restarts at DstReg=1.
